instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter and drives the PC address into the combinational InstructionMemory. It captures the returned 24-bit instruction together with its PC into a small prefetch buffer, and presents entries to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and reload the PC.

Parameters:
DATA_W, 24, instruction width
ADDR_W, 24, PC/address width
DEPTH, 2, prefetch buffer entries (power of 2, >=2)
RESET_PC, 24'd0, PC loaded on reset
PC_STEP, 1, PC increment per fetch (memory is word-addressed)
HALT_OPCODE, 4'hF, value of Instruction[23:20] treated as HALT (used only with FETCH_HALT_EN)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
IM_PC  output  ADDR_W  address to InstructionMemory
IM_Instruction  input  DATA_W  combinational read data for IM_PC
Redirect_Valid  input  1  load new PC, flush buffer
Redirect_PC  input  ADDR_W  redirect target
Out_Valid  output  1  head entry valid
Out_Ready  input  1  decode accepts head entry
Out_PC  output  ADDR_W  PC of head entry
Out_Instruction  output  DATA_W  instruction of head entry
Count  output  $clog2(DEPTH)+1  buffer occupancy
Halted  output  1  (FETCH_HALT_EN only) fetch stopped on HALT

Behaviour:
- Reset low (async): fetch_pc=RESET_PC, buffer empty, Count=0, Out_Valid=0, Out_PC=0, Out_Instruction=0, Halted=0. IM_PC=RESET_PC.
- IM_PC = fetch_pc at all times. Memory data is sampled in the same cycle.
- pop = Out_Valid & Out_Ready. push = !Redirect_Valid & (Count<DEPTH | pop) & !Halted.
- On push: write {fetch_pc, IM_Instruction} at the tail. fetch_pc <= fetch_pc+PC_STEP, truncated to ADDR_W (24'hFFFFFF -> 24'h000000).
- Full with pop in the same cycle: push and pop both occur, and Count is unchanged.
- Latency: a push at edge N makes Out_Valid=1 after edge N. The first Out_Valid occurs one cycle after Reset deasserts.
- Out_PC/Out_Instruction stay stable while Out_Valid & !Out_Ready. Out_* read 0 when the buffer is empty.
- Redirect_Valid has highest priority:
  - Count<=0, pointers reset, fetch_pc<=Redirect_PC, no push.
  - A pop in the same cycle is discarded without error; the consumer must ignore it.
  - Next cycle: Out_Valid=0 and IM_PC=Redirect_PC. The entry at the target appears one cycle later.
- No PC is ever delivered twice or skipped between redirects.
- Reset asserted mid-stream clears everything immediately. Stalled data is discarded.

Optional Feature:
FETCH_HALT_EN
- Defined:
  - A pushed instruction with [23:20]==HALT_OPCODE sets Halted at that edge.
  - The HALT entry itself is delivered.
  - No further pushes occur; fetch_pc stays at HALT PC+PC_STEP.
  - Redirect_Valid clears Halted and resumes fetch at the target.
- Undefined: the Halted port and its logic are absent, and fetch never stops.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W and DATA_W constants
  - RESET_PC and HALT_OPCODE localparams
  - a typedef fetch_entry_t {pc, instr}
- Sub-module fetch_buffer is a DEPTH-entry synchronous FIFO with flush, simultaneous push/pop when full, and count output. instruction_fetch_unit holds the PC, push/pop logic and the halt logic.

Test Plan:
- Memory model mem[i]=24'h100000+i, Out_Ready=1, release Reset -> Out_Valid high one cycle later. Out_PC 0,1,2,3… with matching mem data, one per cycle.
- Out_Ready=0 for 5 cycles after first valid -> Count=2 and IM_PC=2, with Out_PC held at 0. Release -> PCs 0,1,2,3 with no gap or duplicate.
- Buffer full, Redirect_Valid=1 with Redirect_PC=24'd10 -> next cycle Out_Valid=0, Count=0, IM_PC=10. Following cycle Out_PC=10, Out_Instruction=24'h10000A.
- Redirect to 24'hFFFFFF -> Out_PC sequence FFFFFF, 000000, 000001.
- Reset pulled low between clock edges mid-stream -> Out_Valid=0, Out_PC=0, Count=0 and IM_PC=RESET_PC before the next edge.
- FETCH_HALT_EN with mem[5]=24'hF00000 -> PCs 0..5 delivered and Halted=1. IM_PC holds 6 and Count drains to 0. Redirect to 0 -> Halted=0 and fetch resumes at PC 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// fetch_pkg: shared widths, default constants and the buffer entry type for
// the instruction fetch unit.
//   ADDR_W / DATA_W : PC and instruction widths (24 bits each)
//   RESET_PC        : default PC loaded on reset
//   HALT_OPCODE     : default Instruction[23:20] value treated as HALT
//                     (only meaningful when FETCH_HALT_EN is defined)
//   fetch_entry_t   : one prefetch buffer entry {pc, instr}
package fetch_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 24;

    localparam logic [ADDR_W-1:0] RESET_PC    = 24'd0;
    localparam logic [3:0]        HALT_OPCODE = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// fetch_if: bundles the instruction-memory, redirect and decode-side
// signals of the fetch unit.
//   master : fetch unit side (drives IM_PC and the Out_* head entry)
//   slave  : environment side (memory data, redirect, decode ready)
// Handshake: the head entry transfers on a rising edge where
// Out_Valid & Out_Ready; Out_Valid never depends on Out_Ready and the
// Out_* payload holds while Out_Valid & !Out_Ready.
// Halted exists only when FETCH_HALT_EN is defined.
interface fetch_if
    import fetch_pkg::ADDR_W;
    import fetch_pkg::DATA_W;
#(
    parameter int DEPTH = 2
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] IM_PC;
    logic [DATA_W-1:0] IM_Instruction;
    logic              Redirect_Valid;
    logic [ADDR_W-1:0] Redirect_PC;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [ADDR_W-1:0] Out_PC;
    logic [DATA_W-1:0] Out_Instruction;
    logic [CNT_W-1:0]  Count;
`ifdef FETCH_HALT_EN
    logic              Halted;

    modport master (
        output IM_PC, input IM_Instruction,
        input Redirect_Valid, input Redirect_PC,
        output Out_Valid, input Out_Ready, output Out_PC, output Out_Instruction,
        output Count, output Halted
    );

    modport slave (
        input IM_PC, output IM_Instruction,
        output Redirect_Valid, output Redirect_PC,
        input Out_Valid, output Out_Ready, input Out_PC, input Out_Instruction,
        input Count, input Halted
    );
`else
    modport master (
        output IM_PC, input IM_Instruction,
        input Redirect_Valid, input Redirect_PC,
        output Out_Valid, input Out_Ready, output Out_PC, output Out_Instruction,
        output Count
    );

    modport slave (
        input IM_PC, output IM_Instruction,
        output Redirect_Valid, output Redirect_PC,
        input Out_Valid, output Out_Ready, input Out_PC, input Out_Instruction,
        input Count
    );
`endif

endinterface

// File: rtl/instruction_fetch_unit_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO holding fetched {pc, instr}
// entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO (wins over push/pop)
//   push/wdata : write an entry at the tail (caller guarantees room, or a
//                simultaneous pop when full)
//   pop        : drop the head entry (caller guarantees valid)
//   rdata      : head entry, all zeros when empty
//   valid      : FIFO non-empty
//   count      : occupancy, 0..DEPTH
module fetch_buffer
    import fetch_pkg::fetch_entry_t;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale contents are masked by valid below.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign valid = (count != '0);
    assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the program counter, reads the combinational
// instruction memory at IM_PC every cycle and queues {pc, instr} entries in a
// small prefetch buffer that decode drains over a valid/ready handshake.
// A redirect flushes the buffer and reloads the PC.
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : fetch_if.master (IM_PC/IM_Instruction, Redirect_*, Out_*, Count,
//           and Halted when FETCH_HALT_EN is defined)
// Optional build macro FETCH_HALT_EN: a pushed instruction whose top nibble
// equals HALT_OPCODE is delivered and then stops fetching until a redirect.
module instruction_fetch_unit
    import fetch_pkg::ADDR_W;
    import fetch_pkg::DATA_W;
    import fetch_pkg::fetch_entry_t;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int                PC_STEP  = 1
`ifdef FETCH_HALT_EN
    ,
    parameter logic [3:0]        HALT_OPCODE = fetch_pkg::HALT_OPCODE
`endif
) (
    input  logic   Clock,
    input  logic   Reset,
    fetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic              push;
    logic              pop;
    logic              out_valid;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      wdata;
    fetch_entry_t      head;

    assign pop = out_valid & bus.Out_Ready;

`ifdef FETCH_HALT_EN
    logic halted;

    assign push = !bus.Redirect_Valid && ((count < CNT_W'(DEPTH)) || pop) && !halted;

    // Halt is raised by the edge that pushes the HALT word, so that word is
    // still delivered; the PC has already stepped past it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            halted <= 1'b0;
        end else if (bus.Redirect_Valid) begin
            halted <= 1'b0;
        end else if (push && (bus.IM_Instruction[DATA_W-1 -: 4] == HALT_OPCODE)) begin
            halted <= 1'b1;
        end
    end

    assign bus.Halted = halted;
`else
    assign push = !bus.Redirect_Valid && ((count < CNT_W'(DEPTH)) || pop);
`endif

    // Full-with-pop still pushes, so a consumer that is always ready sees
    // one new entry per cycle even with the buffer at capacity.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fetch_pc <= RESET_PC;
        end else if (bus.Redirect_Valid) begin
            fetch_pc <= bus.Redirect_PC;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    assign wdata.pc    = fetch_pc;
    assign wdata.instr = bus.IM_Instruction;

    // A pop coinciding with a redirect is swallowed by the flush.
    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk   (Clock),
        .rst_n (Reset),
        .flush (bus.Redirect_Valid),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .valid (out_valid),
        .count (count)
    );

    assign bus.IM_PC           = fetch_pc;
    assign bus.Out_Valid       = out_valid;
    assign bus.Out_PC          = head.pc;
    assign bus.Out_Instruction = head.instr;
    assign bus.Count           = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a table of per-cycle vectors
// (inputs applied for one clock, outputs expected after that edge), then
// hand-written sequences for asynchronous reset, a random-ready stream with
// an in-order PC scoreboard, and the HALT feature when FETCH_HALT_EN is set.
module tb_instruction_fetch_unit;

    logic Clock;
    logic Reset;
    logic halt_inject;

    int n_checks;
    int n_pass;

    fetch_if #(.DEPTH(2)) bus ();

    instruction_fetch_unit #(
        .DEPTH (2)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: mem[i] = 24'h100000 + i, with an optional HALT at 5.
    assign bus.IM_Instruction = (halt_inject && (bus.IM_PC == 24'd5)) ? 24'hF00000
                                                                      : 24'h100000 + bus.IM_PC;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [23:0] rpc);
        bus.Out_Ready      = rdy;
        bus.Redirect_Valid = rv;
        bus.Redirect_PC    = rpc;
    endtask

    // Holds reset for a while, checks the reset state, releases on a negedge.
    task automatic apply_reset();
        Reset = 1'b0;
        #17;
        check("rst_valid", 32'(bus.Out_Valid), 32'd0);
        check("rst_pc",    32'(bus.Out_PC), 32'd0);
        check("rst_instr", 32'(bus.Out_Instruction), 32'd0);
        check("rst_count", 32'(bus.Count), 32'd0);
        check("rst_im_pc", 32'(bus.IM_PC), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rdy;
        logic        rv;
        logic [23:0] rpc;
        logic        ev;
        logic [23:0] epc;
        logic [23:0] ei;
        logic [1:0]  ecnt;
        logic [23:0] eim;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        halt_inject = 1'b0;
        drive(1'b0, 1'b0, 24'd0);

        //            rdy   rv    rpc         ev    epc         ei          cnt   im_pc
        // Stall from the first valid: fills to 2 and holds PC 0.
        vecs[0]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd1, 24'd1};
        vecs[1]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd2, 24'd2};
        vecs[2]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd2, 24'd2};
        vecs[3]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd2, 24'd2};
        vecs[4]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd2, 24'd2};
        vecs[5]  = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd2, 24'd2};
        // Release: full with pop pushes each cycle, no gap or duplicate.
        vecs[6]  = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd1,      24'h100001, 2'd2, 24'd3};
        vecs[7]  = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd2,      24'h100002, 2'd2, 24'd4};
        vecs[8]  = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd3,      24'h100003, 2'd2, 24'd5};
        vecs[9]  = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd4,      24'h100004, 2'd2, 24'd6};
        // Redirect while full.
        vecs[10] = '{1'b0, 1'b1, 24'd10,     1'b0, 24'd0,      24'h000000, 2'd0, 24'd10};
        vecs[11] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd10,     24'h10000A, 2'd1, 24'd11};
        vecs[12] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd11,     24'h10000B, 2'd1, 24'd12};
        // Redirect with a pop in the same cycle, to the top of the PC range.
        vecs[13] = '{1'b1, 1'b1, 24'hFFFFFF, 1'b0, 24'd0,      24'h000000, 2'd0, 24'hFFFFFF};
        vecs[14] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'hFFFFFF, 24'h0FFFFF, 2'd1, 24'd0};
        vecs[15] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd0,      24'h100000, 2'd1, 24'd1};
        vecs[16] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd1,      24'h100001, 2'd1, 24'd2};
        vecs[17] = '{1'b0, 1'b0, 24'd0,      1'b1, 24'd1,      24'h100001, 2'd2, 24'd3};
        vecs[18] = '{1'b1, 1'b0, 24'd0,      1'b1, 24'd2,      24'h100002, 2'd2, 24'd4};

        apply_reset();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            @(negedge Clock);
            check($sformatf("v%0d_valid", i), 32'(bus.Out_Valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_pc", i),    32'(bus.Out_PC), 32'(vecs[i].epc));
            check($sformatf("v%0d_instr", i), 32'(bus.Out_Instruction), 32'(vecs[i].ei));
            check($sformatf("v%0d_count", i), 32'(bus.Count), 32'(vecs[i].ecnt));
            check($sformatf("v%0d_im_pc", i), 32'(bus.IM_PC), 32'(vecs[i].eim));
        end
`ifdef FETCH_HALT_EN
        check("table_halted", 32'(bus.Halted), 32'd0);
`endif

        // ---------------- async reset between edges ----------------
        drive(1'b0, 1'b0, 24'd0);
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        check("async_valid", 32'(bus.Out_Valid), 32'd0);
        check("async_pc",    32'(bus.Out_PC), 32'd0);
        check("async_count", 32'(bus.Count), 32'd0);
        check("async_im_pc", 32'(bus.IM_PC), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // ---------------- random-ready stream, in-order scoreboard ----------------
        for (int i = 0; i < 64; i++) exp_q.push_back(24'(i));
        for (int c = 0; c < 40; c++) begin
            bus.Out_Ready = 1'($urandom_range(0, 1));
            #1;
            check("stream_count_bound", 32'(bus.Count <= 2'd2), 32'd1);
            if (bus.Out_Valid && bus.Out_Ready) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("stream_pc",    32'(bus.Out_PC), 32'(e));
                check("stream_instr", 32'(bus.Out_Instruction), 32'(24'h100000 + e));
            end
            @(negedge Clock);
        end

`ifdef FETCH_HALT_EN
        // ---------------- HALT at PC 5 ----------------
        drive(1'b1, 1'b0, 24'd0);
        halt_inject = 1'b1;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            if (bus.Out_Valid && bus.Out_Ready) got_q.push_back(bus.Out_PC);
        end
        check("halt_delivered", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size(); i++) check("halt_pc_seq", 32'(got_q[i]), 32'(i));
        check("halt_halted", 32'(bus.Halted), 32'd1);
        check("halt_im_pc",  32'(bus.IM_PC), 32'd6);
        check("halt_count",  32'(bus.Count), 32'd0);
        halt_inject = 1'b0;
        drive(1'b1, 1'b1, 24'd0);
        @(negedge Clock);
        drive(1'b1, 1'b0, 24'd0);
        check("resume_halted", 32'(bus.Halted), 32'd0);
        check("resume_im_pc",  32'(bus.IM_PC), 32'd0);
        check("resume_valid0", 32'(bus.Out_Valid), 32'd0);
        @(negedge Clock);
        check("resume_valid1", 32'(bus.Out_Valid), 32'd1);
        check("resume_pc",     32'(bus.Out_PC), 32'd0);
        check("resume_instr",  32'(bus.Out_Instruction), 32'h100000);
`endif

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
